// File: rtl/apb_req_master.sv
// apb_req_master: queues host read/write commands in a small FIFO and runs
// each one as a single req/ready transaction on the downstream slave
// (IDLE -> SETUP -> ACCESS -> DONE), returning one response per command.
module apb_req_master #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              rst,
   // host command side
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   // slave side
   output logic              req,
   output logic              op,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   input  logic              ready,
   input  logic [DATA_W-1:0] rdata,
   // host response side
   output logic              rsp_valid,
   output logic              rsp_op,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   // ---------------------------------------------------------------- FIFO
   logic [FIFO_DEPTH-1:0]             fifo_op_q;
   logic [FIFO_DEPTH-1:0][ADDR_W-1:0] fifo_addr_q;
   logic [FIFO_DEPTH-1:0][DATA_W-1:0] fifo_wdata_q;
   logic [PTR_W-1:0]                  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]                  count_q, count_d;
   logic                              full, empty, push, pop;

   state_t            state_q, state_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              req_q, req_d;
   logic              op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_op_q, rsp_op_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              busy_q, busy_d;

   // Full is decided on the registered count alone, so a pop in the same
   // cycle never opens room for a push.
   assign full      = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign pop       = (state_q == IDLE) && !empty;

   // Occupancy next-state: simultaneous push and pop leave it unchanged.
   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
   end

   // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   // FIFO storage; contents need no reset because occupancy guards reads.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op_q[wr_ptr_q]    <= cmd_op;
         fifo_addr_q[wr_ptr_q]  <= cmd_addr;
         fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
      end
   end

   // ----------------------------------------------------------------- FSM
   // Next-state and next-output decode; all outputs come from registers so
   // req/rsp_valid are decoded from the state being entered.
   always_comb begin
      state_d     = state_q;
      to_cnt_d    = to_cnt_q;
      op_d        = op_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_op_d    = rsp_op_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               op_d    = fifo_op_q[rd_ptr_q];
               addr_d  = fifo_addr_q[rd_ptr_q];
               wdata_d = fifo_wdata_q[rd_ptr_q];
               state_d = SETUP;
            end
         end
         SETUP: begin
            // One req-low cycle with stable addr so the slave sees a clean edge.
            to_cnt_d = '0;
            state_d  = ACCESS;
         end
         ACCESS: begin
            if (ready) begin
               // ready takes priority over a coincident timeout
               rsp_rdata_d = op_q ? rdata : '0;
               rsp_err_d   = 1'b0;
               rsp_op_d    = op_q;
               to_cnt_d    = '0;
               state_d     = DONE;
            end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               rsp_op_d    = op_q;
               to_cnt_d    = '0;
               state_d     = DONE;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         DONE: begin
            to_cnt_d = '0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      req_d       = (state_d == ACCESS);
      rsp_valid_d = (state_d == DONE);
      busy_d      = (count_d != '0) || (state_d != IDLE);
   end

   // State, timeout counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         to_cnt_q    <= '0;
         req_q       <= 1'b0;
         op_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_op_q    <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         to_cnt_q    <= to_cnt_d;
         req_q       <= req_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_op_q    <= rsp_op_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
      end
   end

   assign req       = req_q;
   assign op        = op_q;
   assign addr      = addr_q;
   assign wdata     = wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_op    = rsp_op_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master with a behavioural req/ready slave,
// a bus monitor and a response log.
module tb_apb_req_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_op;
   logic [3:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        req, op;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic        ready;
   logic [31:0] rdata;
   logic        rsp_valid, rsp_op, rsp_err, busy;
   logic [31:0] rsp_rdata;

   apb_req_master #(.ADDR_W(4), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .req(req), .op(op), .addr(addr), .wdata(wdata),
      .ready(ready), .rdata(rdata),
      .rsp_valid(rsp_valid), .rsp_op(rsp_op), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------- slave model
   // ready rises in the delay-th cycle of req high; delay 255 = never.
   logic [31:0] mem [16];
   int          delay = 5;
   int          hi_cnt = 0;
   logic        ready_m = 1'b0;
   logic        stray = 1'b0;
   assign ready = ready_m | stray;

   always @(negedge clk) begin
      if (req) hi_cnt++; else hi_cnt = 0;
      ready_m = 1'b0;
      rdata   = 32'hBAD0_BAD0;
      if (req && hi_cnt == delay) begin
         ready_m = 1'b1;
         if (op) rdata = mem[addr];
         else mem[addr] = wdata;
      end
   end

   // ------------------------------------------------------------- monitor
   logic        req_prev = 1'b0, rsp_prev = 1'b0, seen_fall = 1'b0;
   int          rises = 0, cur_len = 0, last_len = 0, low_cnt = 0;
   int          min_gap = 1000, stab_err = 0, rsp_run_err = 0;
   logic [3:0]  a_ref;
   logic [31:0] w_ref;
   logic        o_ref;
   logic        rsp_op_log[$];
   logic        rsp_err_log[$];
   logic [31:0] rsp_data_log[$];

   always @(negedge clk) begin
      if (req && !req_prev) begin
         rises++;
         a_ref = addr; w_ref = wdata; o_ref = op;
         if (seen_fall && low_cnt < min_gap) min_gap = low_cnt;
         cur_len = 0;
      end
      if (req) begin
         cur_len++;
         if (addr !== a_ref || wdata !== w_ref || op !== o_ref) stab_err++;
      end
      if (!req && req_prev) begin
         last_len = cur_len; seen_fall = 1'b1; low_cnt = 0;
      end
      if (!req) low_cnt++;
      if (rsp_valid) begin
         rsp_op_log.push_back(rsp_op);
         rsp_err_log.push_back(rsp_err);
         rsp_data_log.push_back(rsp_rdata);
         if (rsp_prev) rsp_run_err++;
      end
      req_prev = req;
      rsp_prev = rsp_valid;
   end

   // ------------------------------------------------------------- helpers
   task automatic push(input logic o, input logic [3:0] a, input logic [31:0] d);
      int k = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = o; cmd_addr = a; cmd_wdata = d;
      while (!cmd_ready && k < 200) begin @(negedge clk); k++; end
      chk("push_accept", cmd_ready, 1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int n, input string tag);
      int k = 0;
      while (rsp_data_log.size() < n && k < 300) begin @(posedge clk); k++; end
      chk(tag, rsp_data_log.size(), n);
   endtask

   task automatic wait_req(input string tag);
      int k = 0;
      @(negedge clk);
      while (!req && k < 100) begin @(negedge clk); k++; end
      chk(tag, req, 1);
   endtask

   task automatic chk_rsp(input int i, input string tag, input logic o,
                          input logic [31:0] d, input logic e);
      if (i < rsp_data_log.size()) begin
         chk({tag, "_op"},   rsp_op_log[i],   o);
         chk({tag, "_data"}, rsp_data_log[i], d);
         chk({tag, "_err"},  rsp_err_log[i],  e);
      end else begin
         chk({tag, "_present"}, rsp_data_log.size(), i + 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got hang expected finish");
      $fatal(1);
   end

   initial begin
      int base, r0;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_req", req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_addr_wdata", {op, addr, wdata}, 0);
      chk("rst_rsp", {rsp_op, rsp_err, rsp_rdata}, 0);

      // single write: latency, one req edge, 5-cycle ready
      delay = 5;
      push(1'b0, 4'h3, 32'hDEADBEEF);
      @(negedge clk);
      chk("lat_n1_req", req, 0);
      chk("lat_n1_busy", busy, 1);
      @(negedge clk);
      chk("lat_setup_req", req, 0);
      chk("lat_setup_addr", addr, 4'h3);
      chk("lat_setup_wdata", wdata, 32'hDEADBEEF);
      @(negedge clk);
      chk("lat_access_req", req, 1);
      wait_rsp(1, "wr1_rsp_count");
      chk_rsp(0, "wr1", 1'b0, 32'h0, 1'b0);
      chk("wr1_rises", rises, 1);
      chk("wr1_req_len", last_len, 5);

      // back-to-back writes and reads, in order
      base = rsp_data_log.size();
      push(1'b0, 4'h5, 32'h12345678);
      push(1'b1, 4'h3, 32'h0);
      push(1'b1, 4'h5, 32'h0);
      wait_rsp(base + 3, "b2b_rsp_count");
      chk_rsp(base,     "b2b_wr5", 1'b0, 32'h0, 1'b0);
      chk_rsp(base + 1, "b2b_rd3", 1'b1, 32'hDEADBEEF, 1'b0);
      chk_rsp(base + 2, "b2b_rd5", 1'b1, 32'h12345678, 1'b0);
      chk("b2b_min_gap_ge2", min_gap >= 2, 1);

      // FIFO full while head is stalled in ACCESS
      delay = 8;
      base = rsp_data_log.size();
      push(1'b0, 4'h8, 32'h100);
      wait_req("full_head_req");
      for (int i = 9; i <= 12; i++) push(1'b0, 4'(i), 32'h100 + 32'(i - 8));
      @(negedge clk);
      chk("full_cmd_ready", cmd_ready, 0);
      chk("full_busy", busy, 1);
      push(1'b0, 4'hD, 32'h105);
      wait_rsp(base + 6, "full_rsp_count");
      delay = 2;
      push(1'b1, 4'h8, 32'h0);
      push(1'b1, 4'hD, 32'h0);
      wait_rsp(base + 8, "full_rd_count");
      chk_rsp(base + 6, "full_rd8", 1'b1, 32'h100, 1'b0);
      chk_rsp(base + 7, "full_rd13", 1'b1, 32'h105, 1'b0);

      // timeout, then a normal command
      delay = 255;
      base = rsp_data_log.size();
      push(1'b1, 4'h3, 32'h0);
      wait_rsp(base + 1, "to_rsp_count");
      chk_rsp(base, "to", 1'b1, 32'h0, 1'b1);
      chk("to_req_len", last_len, 8);
      delay = 2;
      push(1'b1, 4'h3, 32'h0);
      wait_rsp(base + 2, "after_to_count");
      chk_rsp(base + 1, "after_to", 1'b1, 32'hDEADBEEF, 1'b0);

      // ready on the last allowed ACCESS cycle wins over timeout
      delay = 8;
      base = rsp_data_log.size();
      push(1'b1, 4'h5, 32'h0);
      wait_rsp(base + 1, "edge_rsp_count");
      chk_rsp(base, "edge", 1'b1, 32'h12345678, 1'b0);
      chk("edge_req_len", last_len, 8);

      // stray ready in IDLE and SETUP is ignored
      delay = 3;
      base = rsp_data_log.size();
      r0 = rises;
      @(negedge clk) stray = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("stray_idle_no_rsp", rsp_data_log.size(), base);
      push(1'b1, 4'h3, 32'h0);
      wait_req("stray_req");
      stray = 1'b0;
      wait_rsp(base + 1, "stray_rsp_count");
      chk_rsp(base, "stray", 1'b1, 32'hDEADBEEF, 1'b0);
      chk("stray_req_len", last_len, 3);
      chk("stray_rises", rises - r0, 1);

      chk("addr_wdata_stable", stab_err, 0);
      chk("rsp_valid_one_cycle", rsp_run_err, 0);

      // reset during ACCESS with two commands queued
      delay = 255;
      base = rsp_data_log.size();
      push(1'b1, 4'h3, 32'h0);
      wait_req("rst_mid_req");
      push(1'b0, 4'h1, 32'h1);
      push(1'b0, 4'h2, 32'h2);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_req", req, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_cmd_ready", cmd_ready, 1);
      chk("rst_mid_rsp_valid", rsp_valid, 0);
      rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("rst_mid_no_rsp", rsp_data_log.size(), base);
      chk("rst_mid_idle_busy", busy, 0);
      chk("rst_mid_mem1_untouched", mem[1], 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
